// File: rtl/counter_pkg.sv
// -----------------------------------------------------------------------------
// counter_pkg
// Purpose : Shared constants for the free-running loadable up-counter.
// Contents:
//   CNT_WIDTH   - counter / load-data width in bits (only 8 is supported)
//   CNT_RST_VAL - value the counter takes on a sampled reset
// -----------------------------------------------------------------------------
package counter_pkg;

  localparam int unsigned CNT_WIDTH = 8;

  localparam logic [CNT_WIDTH-1:0] CNT_RST_VAL = 8'h00;

endpackage : counter_pkg

// File: rtl/counter_if.sv
// -----------------------------------------------------------------------------
// counter_if
// Purpose : Bundles the load bus and count output of the counter so that a
//           driver (master) and the counter side (slave) share one handle.
//           clk is passed in; reset stays a plain scalar outside the bundle.
// Ports   :
//   clk      in  - clock, carried along for agents that need it
// Signals :
//   wdata    - load value, meaningful only while wr = 1
//   wr       - synchronous load strobe, active-high
//   data_cnt - current counter value
// -----------------------------------------------------------------------------
interface counter_if
  import counter_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH
) (
  input logic clk
);

  logic [WIDTH-1:0] wdata;
  logic             wr;
  logic [WIDTH-1:0] data_cnt;

  // Driver of the load bus; observes the count.
  modport master (
    input  clk,
    output wdata,
    output wr,
    input  data_cnt
  );

  // Counter side: consumes the load bus, produces the count.
  modport slave (
    input  clk,
    input  wdata,
    input  wr,
    output data_cnt
  );

endinterface : counter_if

// File: rtl/counter.sv
// -----------------------------------------------------------------------------
// counter
// Purpose : Free-running WIDTH-bit up-counter with synchronous load.
//           Priority on each rising clk edge: reset > load (wr) > increment.
//           Arithmetic wraps modulo 2^WIDTH with no flag or saturation.
// Ports (positional order is fixed: reset, clk, wdata, wr, data_cnt):
//   reset    in  1      synchronous, active-high reset
//   clk      in  1      clock, all state changes on the rising edge
//   wdata    in  WIDTH  load value, sampled only when wr = 1
//   wr       in  1      synchronous load strobe, active-high
//   data_cnt out WIDTH  counter value, driven straight from the register
// -----------------------------------------------------------------------------
module counter
  import counter_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH
) (
  input  logic             reset,
  input  logic             clk,
  input  logic [WIDTH-1:0] wdata,
  input  logic             wr,
  output logic [WIDTH-1:0] data_cnt
);

  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] w_cnt_inc;

  // Width-matched +1; the carry out of the top bit is dropped, giving the
  // FF -> 00 wrap for free.
  assign w_cnt_inc = r_cnt + WIDTH'(1);

  // NOTE: reset is sampled inside the clocked block (no reset in the
  // sensitivity list), so it only acts on a rising edge and a pulse between
  // edges is ignored. State is updated with non-blocking assignments so every
  // flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= WIDTH'(CNT_RST_VAL);
    end else if (wr) begin
      r_cnt <= wdata;
    end else begin
      r_cnt <= w_cnt_inc;
    end
  end

  assign data_cnt = r_cnt;

endmodule : counter

// File: tb/tb_counter.sv
// -----------------------------------------------------------------------------
// tb_counter
// Directed bench for counter. Inputs change 1 ns after a rising edge and the
// count is sampled 1 ns after the next rising edge. Expected values are
// hand-computed constants in each scenario table.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_counter;
  import counter_pkg::*;

  localparam int W = CNT_WIDTH;

  logic clk;
  logic reset;

  int n_checks;
  int n_errors;

  counter_if #(.WIDTH(W)) bus (.clk(clk));

  counter #(.WIDTH(W)) dut (
    .reset    (reset),
    .clk      (clk),
    .wdata    (bus.wdata),
    .wr       (bus.wr),
    .data_cnt (bus.data_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Two reset edges give 00, 00; release gives 01, 02, 03.
  task automatic test_reset();
    logic           v_rst [5];
    logic [W-1:0]   v_exp [5];
    v_rst = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    v_exp = '{8'h00, 8'h00, 8'h01, 8'h02, 8'h03};
    bus.wr    = 1'b0;
    bus.wdata = 8'h00;
    for (int i = 0; i < 5; i++) begin
      reset = v_rst[i];
      tick();
      n_checks++;
      if (bus.data_cnt !== v_exp[i]) begin
        n_errors++;
        $display("FAIL reset[%0d]: data_cnt=%h expected=%h", i, bus.data_cnt, v_exp[i]);
      end
    end
  endtask

  // Single-edge load of 55 then counting 56, 57.
  task automatic test_load();
    logic           v_wr [3];
    logic [W-1:0]   v_exp [3];
    v_wr  = '{1'b1, 1'b0, 1'b0};
    v_exp = '{8'h55, 8'h56, 8'h57};
    reset     = 1'b0;
    bus.wdata = 8'h55;
    for (int i = 0; i < 3; i++) begin
      bus.wr = v_wr[i];
      tick();
      n_checks++;
      if (bus.data_cnt !== v_exp[i]) begin
        n_errors++;
        $display("FAIL load[%0d]: data_cnt=%h expected=%h", i, bus.data_cnt, v_exp[i]);
      end
    end
  endtask

  // Load FD then count through the wrap: FE, FF, 00, 01.
  task automatic test_wrap();
    logic           v_wr [5];
    logic [W-1:0]   v_exp [5];
    v_wr  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    v_exp = '{8'hFD, 8'hFE, 8'hFF, 8'h00, 8'h01};
    reset     = 1'b0;
    bus.wdata = 8'hFD;
    for (int i = 0; i < 5; i++) begin
      bus.wr = v_wr[i];
      tick();
      n_checks++;
      if (bus.data_cnt !== v_exp[i]) begin
        n_errors++;
        $display("FAIL wrap[%0d]: data_cnt=%h expected=%h", i, bus.data_cnt, v_exp[i]);
      end
    end
  endtask

  // Loading FF is legal and the next counting edge gives 00.
  task automatic test_load_ff();
    logic           v_wr [2];
    logic [W-1:0]   v_exp [2];
    v_wr  = '{1'b1, 1'b0};
    v_exp = '{8'hFF, 8'h00};
    reset     = 1'b0;
    bus.wdata = 8'hFF;
    for (int i = 0; i < 2; i++) begin
      bus.wr = v_wr[i];
      tick();
      n_checks++;
      if (bus.data_cnt !== v_exp[i]) begin
        n_errors++;
        $display("FAIL load_ff[%0d]: data_cnt=%h expected=%h", i, bus.data_cnt, v_exp[i]);
      end
    end
  endtask

  // reset beats wr (wdata AA) -> 00; then reset mid-count -> 00; release -> 01.
  task automatic test_priority();
    logic           v_rst [5];
    logic           v_wr  [5];
    logic [W-1:0]   v_wd  [5];
    logic [W-1:0]   v_exp [5];
    v_rst = '{1'b1,  1'b0,  1'b0,  1'b1,  1'b0};
    v_wr  = '{1'b1,  1'b0,  1'b0,  1'b0,  1'b0};
    v_wd  = '{8'hAA, 8'h00, 8'h00, 8'h00, 8'h00};
    v_exp = '{8'h00, 8'h01, 8'h02, 8'h00, 8'h01};
    for (int i = 0; i < 5; i++) begin
      reset     = v_rst[i];
      bus.wr    = v_wr[i];
      bus.wdata = v_wd[i];
      tick();
      n_checks++;
      if (bus.data_cnt !== v_exp[i]) begin
        n_errors++;
        $display("FAIL priority[%0d]: data_cnt=%h expected=%h", i, bus.data_cnt, v_exp[i]);
      end
    end
  endtask

  // wr held for three edges reloads 10, 20, 30; counting resumes at 31.
  task automatic test_back_to_back();
    logic           v_wr  [4];
    logic [W-1:0]   v_wd  [4];
    logic [W-1:0]   v_exp [4];
    v_wr  = '{1'b1,  1'b1,  1'b1,  1'b0};
    v_wd  = '{8'h10, 8'h20, 8'h30, 8'h77};
    v_exp = '{8'h10, 8'h20, 8'h30, 8'h31};
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.wr    = v_wr[i];
      bus.wdata = v_wd[i];
      tick();
      n_checks++;
      if (bus.data_cnt !== v_exp[i]) begin
        n_errors++;
        $display("FAIL back_to_back[%0d]: data_cnt=%h expected=%h", i, bus.data_cnt, v_exp[i]);
      end
    end
  endtask

  // Pulses between edges must not be seen: reset for 4 ns, then a wr pulse.
  // Count is 31 on entry (left by test_back_to_back).
  task automatic test_glitch();
    reset     = 1'b0;
    bus.wr    = 1'b0;
    bus.wdata = 8'hEE;
    #2;                 // edge + 3 ns
    reset = 1'b1;
    #4;                 // edge + 7 ns
    reset = 1'b0;
    tick();
    n_checks++;
    if (bus.data_cnt !== 8'h32) begin
      n_errors++;
      $display("FAIL glitch_reset: data_cnt=%h expected=%h", bus.data_cnt, 8'h32);
    end
    #2;
    bus.wr = 1'b1;
    #4;
    bus.wr = 1'b0;
    tick();
    n_checks++;
    if (bus.data_cnt !== 8'h33) begin
      n_errors++;
      $display("FAIL glitch_wr: data_cnt=%h expected=%h", bus.data_cnt, 8'h33);
    end
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    reset     = 1'b1;
    bus.wr    = 1'b0;
    bus.wdata = '0;
    #1;
    test_reset();
    test_load();
    test_wrap();
    test_load_ff();
    test_priority();
    test_back_to_back();
    test_glitch();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_counter

// File: doc/counter.md
COUNTER -- requirements
Module: counter

Interface
REQ-001 Parameter WIDTH, default 8, counter and load-data width in bits; the only legal value is 8.
REQ-002 Port order SHALL be reset, clk, wdata, wr, data_cnt, so that positional instantiation works.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on the clk rising edge.
REQ-005 wdata  input  WIDTH  load value, sampled only when wr=1.
REQ-006 wr  input  1  synchronous load strobe, active-high.
REQ-007 data_cnt  output  WIDTH  current counter value, driven directly from a register with no combinational path from inputs.

Function
REQ-008 The counter SHALL be a free-running up-counter: each rising edge with reset=0 and wr=0 sets data_cnt to data_cnt+1.
REQ-009 Arithmetic SHALL be unsigned modulo 2^WIDTH: 8'hFF wraps to 8'h00, with no flag, stall or saturation.
REQ-010 A rising edge with reset=0 and wr=1 SHALL set data_cnt to wdata, with one-cycle latency.
REQ-011 Counting SHALL resume from the loaded value: the edge after a load with wr=0 yields wdata+1.
REQ-012 wr held high for N edges SHALL reload wdata on every edge; data_cnt tracks wdata and does not count.
REQ-013 Loading 8'hFF SHALL be legal; the next counting edge yields 8'h00.
REQ-014 Priority SHALL be reset > wr > increment.
REQ-015 Inputs SHALL be sampled only at the rising edge; glitches or pulses between edges have no effect.
REQ-016 There SHALL be no enable, no down-count and no terminal-count output.

Reset
REQ-017 With reset=1 at a rising edge, data_cnt SHALL become 8'h00 on that edge, regardless of wr and wdata.
REQ-018 While reset stays high, data_cnt SHALL hold 8'h00.
REQ-019 On the first edge with reset=0, data_cnt SHALL become 8'h01, or wdata if wr=1.
REQ-020 A reset pulse that does not span a rising edge SHALL have no effect, since reset is synchronous.
REQ-021 Before the first sampled reset, data_cnt is unspecified; the design SHALL NOT depend on an initial value and SHALL contain no initial blocks.
REQ-022 Reset asserted mid-count or during a load SHALL abort that operation; the next value is 8'h00.

Structure
REQ-023 A shared package counter_pkg SHALL hold the CNT_WIDTH constant (8) and the reset-value constant (8'h00); the module parameter WIDTH defaults from CNT_WIDTH.
REQ-024 There SHALL be a single flat module with one state register and no sub-modules.
REQ-025 Synthesis SHALL infer exactly WIDTH flip-flops with synchronous reset, with no latches.

Verification
REQ-026 Hold reset=1 across two edges, then release -> data_cnt = 00 and 00, then 01, 02, 03 on successive edges.
REQ-027 After reset, set wr=1 and wdata=8'h55 for one edge -> data_cnt = 55 on that edge, then 56, 57.
REQ-028 Count from 8'hFD -> FE, FF, 00, 01 (wrap with no glitch).
REQ-029 Set reset=1, wr=1, wdata=8'hAA on the same edge -> data_cnt = 00.
REQ-030 Hold wr=1 for 3 edges with wdata = 10, 20, 30 -> data_cnt = 10, 20, 30, then 31 after wr drops.
REQ-031 Pulse reset high for 4 ns strictly between 10 ns-period edges -> the count continues unaffected.
